// File: rtl/noc_output_vc_scheduler.sv
// Per-output-port VC scheduler: round-robin packet arbitration with wormhole locking
// and per-VC downstream credit counters.
module noc_output_vc_scheduler #(
  parameter int CHANNELS     = 2,
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1),
  parameter int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [CHANNELS-1:0]       flit_valid_i,
  input  logic [CHANNELS-1:0]       flit_sop_i,
  input  logic [CHANNELS-1:0]       flit_eop_i,
  input  logic [CHANNELS-1:0]       credit_return_i,
  output logic [CHANNELS-1:0]       flit_pop_o,
  output logic                      send_o,
  output logic [SEL_W-1:0]          sel_vc_o,
  output logic [CHANNELS*CNT_W-1:0] credit_o,
  output logic                      lock_o,
  output logic [SEL_W-1:0]          owner_o,
  output logic                      err_o
);

  typedef enum logic {StIdle, StLocked} state_t;

  localparam logic [CNT_W-1:0] FullCredit = CNT_W'(CREDIT_DEPTH);

  state_t              r_state, w_state_d;
  logic [SEL_W-1:0]    r_owner, w_owner_d;
  logic [SEL_W-1:0]    r_rr, w_rr_d;
  logic [SEL_W-1:0]    w_win, w_sel;
  logic [CNT_W-1:0]    r_credit   [CHANNELS];
  logic [CNT_W-1:0]    w_credit_d [CHANNELS];
  logic [CHANNELS-1:0] w_elig, w_pop;
  logic                w_found, w_proto_err, w_ovf_err, r_err;

  // Eligibility uses registered credit only; a same-cycle return never bypasses.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_elig[i] = flit_valid_i[i] & (r_credit[i] != '0);
    end
  end

  // First eligible start-of-packet VC scanning upward from rr with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_found && w_elig[(int'(r_rr) + k) % CHANNELS]
          && flit_sop_i[(int'(r_rr) + k) % CHANNELS]) begin
        w_found = 1'b1;
        w_win   = SEL_W'((int'(r_rr) + k) % CHANNELS);
      end
    end
  end

  assign w_proto_err = (r_state == StIdle) && (|(w_elig & ~flit_sop_i));

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_rr_d    = r_rr;
    w_pop     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_pop[w_win] = 1'b1;
          w_rr_d       = (int'(w_win) == CHANNELS - 1) ? '0 : w_win + SEL_W'(1);
          if (!flit_eop_i[w_win]) begin
            w_state_d = StLocked;
            w_owner_d = w_win;
          end
        end
      end
      StLocked: begin
        if (w_elig[r_owner]) begin
          w_pop[r_owner] = 1'b1;
          if (flit_eop_i[r_owner]) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (noc_rst) begin
      w_pop = '0;
    end
  end

  always_comb begin
    w_ovf_err = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_credit_d[i] = r_credit[i];
      if (w_pop[i] && !credit_return_i[i]) begin
        w_credit_d[i] = r_credit[i] - CNT_W'(1);
      end else if (!w_pop[i] && credit_return_i[i]) begin
        // A return into a full counter saturates and flags the downstream as misbehaving.
        if (r_credit[i] == FullCredit) begin
          w_ovf_err = 1'b1;
        end else begin
          w_credit_d[i] = r_credit[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_pop[i]) begin
        w_sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    credit_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      credit_o[i*CNT_W +: CNT_W] = r_credit[i];
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_rr    <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_credit[i] <= FullCredit;
      end
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_rr    <= w_rr_d;
      r_err   <= r_err | w_proto_err | w_ovf_err;
      for (int i = 0; i < CHANNELS; i++) begin
        r_credit[i] <= w_credit_d[i];
      end
    end
  end

  assign flit_pop_o = w_pop;
  assign send_o     = |w_pop;
  assign sel_vc_o   = w_sel;
  assign lock_o     = (r_state == StLocked);
  assign owner_o    = (r_state == StLocked) ? r_owner : '0;
  assign err_o      = r_err;

endmodule
